// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Holds the immediate-type op codes, the default XLEN and the
// elastic-buffer occupancy encodings.
package imm_gen_pipe_pkg;

   localparam int unsigned XLEN_DFLT = 32;
   localparam int unsigned OP_W      = 3;

   // Immediate-type select codes
   localparam logic [OP_W-1:0] IMM_NONE  = 3'd0;
   localparam logic [OP_W-1:0] IMM_I     = 3'd1;
   localparam logic [OP_W-1:0] IMM_SHIFT = 3'd2;
   localparam logic [OP_W-1:0] IMM_S     = 3'd3;
   localparam logic [OP_W-1:0] IMM_U     = 3'd4;
   localparam logic [OP_W-1:0] IMM_B     = 3'd5;
   localparam logic [OP_W-1:0] IMM_J     = 3'd6;
   localparam logic [OP_W-1:0] IMM_Z     = 3'd7;

   // Elastic buffer occupancy
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } cnt_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational immediate extractor/extender.
// Ports:
//   inst  - instruction bits [31:7] (opcode bits are never needed)
//   op    - immediate type (IMM_* code)
//   imm_c - XLEN-wide extended immediate
module imm_ext_comb
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DFLT
) (
   input  logic [31:7]     inst,
   input  logic [OP_W-1:0] op,
   output logic [XLEN-1:0] imm_c
);

   if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
      $error("imm_ext_comb: XLEN must be 32 or 64");
   end

   // raw_c is already sign-extended to 32 bits; sext_c says whether
   // bit 31 must also be replicated above bit 31 (RV64).
   logic [31:0] raw_c;
   logic        sext_c;

   always_comb begin
      raw_c  = '0;
      sext_c = 1'b0;
      case (op)
         IMM_I: begin
            raw_c  = {{20{inst[31]}}, inst[31:20]};
            sext_c = 1'b1;
         end
         IMM_SHIFT: begin
            if (XLEN == 64) raw_c = {26'd0, inst[25:20]};
            else            raw_c = {27'd0, inst[24:20]};
         end
         IMM_S: begin
            raw_c  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            sext_c = 1'b1;
         end
         IMM_U: begin
            raw_c  = {inst[31:12], 12'd0};
            sext_c = 1'b1;
         end
         IMM_B: begin
            raw_c  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            sext_c = 1'b1;
         end
         IMM_J: begin
            raw_c  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            sext_c = 1'b1;
         end
         IMM_Z: begin
            raw_c = {27'd0, inst[19:15]};
         end
         default: begin
            raw_c = '0;
         end
      endcase
   end

   assign imm_c = sext_c ? XLEN'($signed(raw_c)) : XLEN'(raw_c);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry elastic output buffer.
// in_ready and out_valid are registers, so in_ready never depends
// combinationally on out_ready.
// Ports:
//   clk, rst             - clock, async active-high reset
//   flush                - synchronous discard of all buffered entries
//   in_valid/in_ready    - request handshake
//   in_inst/in_op/in_tag - instruction, immediate type, sideband tag
//   out_valid/out_ready  - result handshake (head entry)
//   out_imm/out_tag      - head entry immediate and tag
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DFLT,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [OP_W-1:0]  in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  new_imm_c;
   logic             push_c;
   logic             pop_c;
   logic             unused_c;

   cnt_e             cnt_q, cnt_d;
   logic [XLEN-1:0]  head_imm_d, tail_imm_q, tail_imm_d;
   logic [TAG_W-1:0] head_tag_d, tail_tag_q, tail_tag_d;

   // Opcode field carries no immediate bits
   assign unused_c = ^in_inst[6:0];

   imm_ext_comb #(.XLEN(XLEN)) u_ext (
      .inst  (in_inst[31:7]),
      .op    (in_op),
      .imm_c (new_imm_c)
   );

   assign push_c = in_valid && in_ready;
   assign pop_c  = out_valid && out_ready;

   // Occupancy next-state and head/tail data movement
   always_comb begin
      cnt_d      = cnt_q;
      head_imm_d = out_imm;
      head_tag_d = out_tag;
      tail_imm_d = tail_imm_q;
      tail_tag_d = tail_tag_q;
      if (flush) begin
         cnt_d = CNT_EMPTY;
      end else begin
         case (cnt_q)
            CNT_EMPTY: begin
               if (push_c) begin
                  cnt_d      = CNT_ONE;
                  head_imm_d = new_imm_c;
                  head_tag_d = in_tag;
               end
            end
            CNT_ONE: begin
               if (push_c && pop_c) begin
                  // head drains while the new entry replaces it
                  head_imm_d = new_imm_c;
                  head_tag_d = in_tag;
               end else if (push_c) begin
                  cnt_d      = CNT_FULL;
                  tail_imm_d = new_imm_c;
                  tail_tag_d = in_tag;
               end else if (pop_c) begin
                  cnt_d = CNT_EMPTY;
               end
            end
            CNT_FULL: begin
               if (pop_c) begin
                  cnt_d      = CNT_ONE;
                  head_imm_d = tail_imm_q;
                  head_tag_d = tail_tag_q;
               end
            end
            default: begin
               cnt_d = CNT_EMPTY;
            end
         endcase
      end
   end

   // State, flag and payload registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= CNT_EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_imm    <= '0;
         out_tag    <= '0;
         tail_imm_q <= '0;
         tail_tag_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         in_ready   <= (cnt_d != CNT_FULL);
         out_valid  <= (cnt_d != CNT_EMPTY);
         out_imm    <= head_imm_d;
         out_tag    <= head_tag_d;
         tail_imm_q <= tail_imm_d;
         tail_tag_q <= tail_tag_d;
      end
   end

endmodule
